int_ctrl: RTL and testbench
===========================

# int_ctrl

Parametrised N-channel interrupt controller between the system's peripheral interrupt sources (serial port receive-ready, ASCII keyboard, future timers/DMA) and the CPU's interrupt input. It replaces ad-hoc per-device request/ack wiring with:
- a uniform register window on the physical memory controller;
- per-channel enable, per-channel edge/level mode and fixed priority;
- claim/complete nesting;
- a device acknowledge pulse on claim.

## Interface
- NCHAN, 4: number of interrupt channels, 1..16; channel 0 is highest priority.
- IDW, 4: width of channel index fields; fixed, covers NCHAN ≤ 16.
- clk  in  1  system clock (50 MHz domain).
- rst  in  1  reset; one clock, asynchronous, active-low.
- irq_req  in  NCHAN  device request lines; may be asynchronous to clk.
- irq_ack  out  NCHAN  one-cycle acknowledge pulse to the device, issued on claim.
- reg_sel  in  1  register access strobe, one cycle per access.
- reg_we  in  1  1 = write, 0 = read; qualified by reg_sel.
- reg_addr  in  3  word offset within the register window.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data; registered.
- cpu_int  out  1  interrupt request to the CPU; registered.
- cpu_int_id  out  IDW  index of the highest-priority eligible channel; 0 when cpu_int = 0.

## Operation
Register map (word offsets). Bits at or above NCHAN read 0 and ignore writes.
- 0 PENDING: read-only, except write-1-to-clear on edge-mode bits; writes to level bits are ignored.
- 1 ENABLE: read/write, reset 0.
- 2 MODE: read/write; 1 = edge, 0 = level; reset 0.
- 3 CLAIM: read returns {valid[31], 27'b0, id[IDW-1:0]}; writes ignored.
- 4 COMPLETE: write wdata[IDW-1:0] to clear that channel's in-service bit; reads return 0.
- 5 RAW: read-only, synchronised irq_req.
- 6, 7: read 0, writes ignored.

Per-channel pending:
- Level mode: pending = synchronised request.
- Edge mode: pending is set on a synchronised 0→1 transition.
- Edge mode: pending is cleared by claim or by write-1-to-clear.

Eligibility and in-service:
- Eligible channel: pending & enable & ~in_service, and strictly higher priority (lower index) than the highest-priority in-service channel.
- cpu_int = any channel eligible.
- cpu_int_id = lowest eligible index.

CLAIM read, when valid:
- the lowest eligible channel's in-service bit is set;
- its edge-mode pending bit is cleared;
- irq_ack[id] pulses.

CLAIM read with nothing eligible returns 0 and has no side effects.

Boundary rules:
- New edge in the same cycle as that channel's claim or W1C: the edge wins and pending stays 1.
- COMPLETE of a channel not in service: ignored.
- COMPLETE with id ≥ NCHAN: ignored.
- Level channel completed while its request is still high: eligible again.
- Disabling a pending channel: pending is kept; the channel is no longer eligible.
- Reset mid-operation clears every register, synchroniser and in-service bit.

Reset values: irq_ack 0, reg_rdata 0, cpu_int 0, cpu_int_id 0.

## Timing
- irq_req passes through a 2-flop synchroniser.
- Pending is set at the 3rd rising edge after irq_req changes.
- cpu_int rises 1 cycle after pending is set, i.e. 4 edges total.
- Register read: reg_rdata is valid the cycle after the reg_sel cycle and holds until the next read.
- Register write, CLAIM side effects and COMPLETE take effect at the edge ending the reg_sel cycle.
- irq_ack[id] is high for exactly the cycle after the claim cycle.
- cpu_int/cpu_int_id reflect the new state one cycle after the edge that changes eligibility.
- Back-to-back accesses, one per cycle, are supported.
- A claim followed immediately by another claim sees the first claim's in-service bit.

## Structure
- Shared header int_ctrl_def.vh (alongside vga_def.vh) holds:
  - register offsets INTC_PENDING … INTC_RAW;
  - INTC_IDW;
  - CLAIM valid bit position 31.
- Sub-module int_sync_edge, one instance per channel, provides:
  - 2-flop synchroniser;
  - previous-value flop;
  - outputs: level and rise.
- Top level holds:
  - the registers;
  - the priority encoder (lowest index wins);
  - the in-service mask;
  - the register mux.

## Test plan
- Reset, then NCHAN=4, ENABLE=4'b0010, level ch1 raised → cpu_int=1 and cpu_int_id=1 four edges later; CLAIM returns 0x80000001; irq_ack[1] pulses for one cycle.
- Edge ch2 pulsed while ch1 in service → cpu_int stays 0 until COMPLETE(1); then CLAIM returns 0x80000002 and PENDING bit2 clears.
- Ch3 in service, ch0 edge arrives → cpu_int=1 with id 0 (nesting); CLAIM 0x80000000; both in service; COMPLETE(0) → cpu_int=0.
- Edge ch2 rise in the same cycle as W1C of PENDING bit2 → PENDING reads 0x4.
- CLAIM with nothing eligible → 0x00000000 and no irq_ack; COMPLETE(7) with NCHAN=4 → no state change.
- rst asserted mid-claim (between reg_sel and rdata) → all outputs 0 immediately; ENABLE reads 0 after release.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// int_ctrl_pkg
// Shared definitions for the interrupt controller and the code that drives it:
//   - register word offsets inside the controller's window
//   - width of channel index fields
//   - bit position of the "valid" flag in a CLAIM read
// -----------------------------------------------------------------------------
package int_ctrl_pkg;

   localparam int INTC_IDW             = 4;
   localparam int INTC_CLAIM_VALID_BIT = 31;

   // Offsets 6 and 7 are unmapped: they read 0 and ignore writes.
   typedef enum logic [2:0] {
      INTC_PENDING  = 3'd0,
      INTC_ENABLE   = 3'd1,
      INTC_MODE     = 3'd2,
      INTC_CLAIM    = 3'd3,
      INTC_COMPLETE = 3'd4,
      INTC_RAW      = 3'd5
   } intc_reg_e;

endpackage

// File: rtl/int_ctrl_if.sv
// -----------------------------------------------------------------------------
// int_ctrl_if
// Register access bus into the interrupt controller window.
//   reg_sel   : access strobe, one cycle per access
//   reg_we    : 1 = write, 0 = read (qualified by reg_sel)
//   reg_addr  : word offset within the window
//   reg_wdata : write data
//   reg_rdata : read data, registered, valid the cycle after reg_sel
// Protocol: there is no back-pressure. Every cycle with reg_sel high is exactly
// one access, accepted at the rising edge that ends it; accesses may be issued
// back-to-back. A read's data appears on reg_rdata after that edge and holds
// until the next read completes.
// -----------------------------------------------------------------------------
interface int_ctrl_if;
   import int_ctrl_pkg::*;

   logic        reg_sel;
   logic        reg_we;
   logic [2:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata;

   modport master (
      output reg_sel, reg_we, reg_addr, reg_wdata,
      input  reg_rdata
   );

   modport slave (
      input  reg_sel, reg_we, reg_addr, reg_wdata,
      output reg_rdata
   );

endinterface

// File: rtl/int_ctrl_sync_edge.sv
// -----------------------------------------------------------------------------
// int_ctrl_sync_edge
// Per-channel front end: brings an asynchronous request line into the clk
// domain and flags its rising edge.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_i      : raw device request (may be asynchronous)
//   level_o    : synchronised request
//   rise_o     : high for one cycle after the synchronised request goes 0->1
// -----------------------------------------------------------------------------
module int_ctrl_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic req_i,
   output logic level_o,
   output logic rise_o
);

   logic s1_q;
   logic s2_q;
   logic prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         s1_q   <= req_i;
         s2_q   <= s1_q;
         prev_q <= s2_q;
      end
   end

   assign level_o = s2_q;
   assign rise_o  = s2_q & ~prev_q;

endmodule

// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl
// N-channel fixed-priority interrupt controller (channel 0 highest) with
// per-channel enable, edge/level mode and claim/complete nesting.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : register window (int_ctrl_if.slave)
//   irq_req     : device request lines, asynchronous
//   irq_ack     : one-cycle acknowledge to the claimed device
//   cpu_int     : registered interrupt request to the CPU
//   cpu_int_id  : registered index of the best eligible channel (0 if none)
// -----------------------------------------------------------------------------
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int NCHAN = 4,
   parameter int IDW   = INTC_IDW
) (
   input  logic             clk,
   input  logic             rst_n,
   int_ctrl_if.slave        bus,
   input  logic [NCHAN-1:0] irq_req,
   output logic [NCHAN-1:0] irq_ack,
   output logic             cpu_int,
   output logic [IDW-1:0]   cpu_int_id
);

   logic [NCHAN-1:0] level, rise;
   logic [NCHAN-1:0] pend_q, pend_d;
   logic [NCHAN-1:0] en_q, en_d;
   logic [NCHAN-1:0] mode_q, mode_d;
   logic [NCHAN-1:0] insvc_q, insvc_d;
   logic [NCHAN-1:0] ack_q;
   logic [31:0]      rdata_q, rdata_d;
   logic             int_q;
   logic [IDW-1:0]   id_q;

   logic [NCHAN-1:0] elig, claim_oh, done_oh, w1c;
   logic             blocked, any_elig, rd, wr, claim;
   logic [IDW-1:0]   top_id;
   logic             unused_wdata;

   for (genvar g = 0; g < NCHAN; g++) begin : g_sync
      int_ctrl_sync_edge u_sync (
         .clk     (clk),
         .rst_n   (rst_n),
         .req_i   (irq_req[g]),
         .level_o (level[g]),
         .rise_o  (rise[g])
      );
   end

   // Walking from channel 0 upward, the first in-service bit blocks itself and
   // every lower-priority channel, so only strictly higher priority can nest.
   always_comb begin
      blocked = 1'b0;
      elig    = '0;
      for (int i = 0; i < NCHAN; i++) begin
         blocked = blocked | insvc_q[i];
         elig[i] = pend_q[i] & en_q[i] & ~blocked;
      end
   end

   // Lowest eligible index wins.
   always_comb begin
      top_id   = '0;
      any_elig = 1'b0;
      for (int i = NCHAN - 1; i >= 0; i--) begin
         if (elig[i]) begin
            top_id   = IDW'(i);
            any_elig = 1'b1;
         end
      end
   end

   assign rd    = bus.reg_sel & ~bus.reg_we;
   assign wr    = bus.reg_sel & bus.reg_we;
   assign claim = rd & (bus.reg_addr == INTC_CLAIM) & any_elig;

   // COMPLETE ids at or above NCHAN match no channel and so have no effect.
   always_comb begin
      claim_oh = '0;
      done_oh  = '0;
      for (int i = 0; i < NCHAN; i++) begin
         claim_oh[i] = claim & (top_id == IDW'(i));
         done_oh[i]  = wr & (bus.reg_addr == INTC_COMPLETE) &
                       (bus.reg_wdata[IDW-1:0] == IDW'(i));
      end
   end

   // Write-1-to-clear only reaches edge-mode bits.
   assign w1c = (wr && (bus.reg_addr == INTC_PENDING)) ?
                (bus.reg_wdata[NCHAN-1:0] & mode_q) : '0;

   always_comb begin
      pend_d = '0;
      for (int i = 0; i < NCHAN; i++) begin
         // A fresh edge beats a same-cycle claim or W1C.
         pend_d[i] = mode_q[i] ? (rise[i] | (pend_q[i] & ~(claim_oh[i] | w1c[i])))
                               : level[i];
      end
      insvc_d = (insvc_q | claim_oh) & ~done_oh;
      en_d    = en_q;
      mode_d  = mode_q;
      if (wr && (bus.reg_addr == INTC_ENABLE)) en_d   = bus.reg_wdata[NCHAN-1:0];
      if (wr && (bus.reg_addr == INTC_MODE))   mode_d = bus.reg_wdata[NCHAN-1:0];
      rdata_d = rdata_q;
      if (rd) begin
         rdata_d = '0;
         case (bus.reg_addr)
            INTC_PENDING: rdata_d = 32'(pend_q);
            INTC_ENABLE:  rdata_d = 32'(en_q);
            INTC_MODE:    rdata_d = 32'(mode_q);
            INTC_CLAIM: begin
               rdata_d[INTC_CLAIM_VALID_BIT] = any_elig;
               rdata_d[IDW-1:0]              = top_id;
            end
            INTC_RAW:     rdata_d = 32'(level);
            default:      rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q  <= '0;
         en_q    <= '0;
         mode_q  <= '0;
         insvc_q <= '0;
         ack_q   <= '0;
         rdata_q <= '0;
         int_q   <= 1'b0;
         id_q    <= '0;
      end else begin
         pend_q  <= pend_d;
         en_q    <= en_d;
         mode_q  <= mode_d;
         insvc_q <= insvc_d;
         ack_q   <= claim_oh;
         rdata_q <= rdata_d;
         int_q   <= any_elig;
         id_q    <= top_id;
      end
   end

   assign irq_ack       = ack_q;
   assign cpu_int       = int_q;
   assign cpu_int_id    = id_q;
   assign bus.reg_rdata = rdata_q;

   // Upper write-data bits beyond the channel count carry no state.
   assign unused_wdata = ^bus.reg_wdata;

endmodule

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl
// Directed bench for int_ctrl with NCHAN = 4. Read data expectations go
// through a queue: pushed when the read is issued, popped when rdata is valid.
// -----------------------------------------------------------------------------
module tb_int_ctrl;
   import int_ctrl_pkg::*;

   localparam int NCHAN = 4;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NCHAN-1:0]    irq_req;
   logic [NCHAN-1:0]    irq_ack;
   logic                cpu_int;
   logic [INTC_IDW-1:0] cpu_int_id;

   int_ctrl_if bus ();

   int_ctrl #(.NCHAN(NCHAN)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .irq_req    (irq_req),
      .irq_ack    (irq_ack),
      .cpu_int    (cpu_int),
      .cpu_int_id (cpu_int_id)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic reg_write(input logic [2:0] addr, input logic [31:0] data);
      bus.reg_sel   = 1'b1;
      bus.reg_we    = 1'b1;
      bus.reg_addr  = addr;
      bus.reg_wdata = data;
      tick(1);
      bus.reg_sel   = 1'b0;
      bus.reg_we    = 1'b0;
      bus.reg_wdata = '0;
   endtask

   task automatic reg_read(input string tag, input logic [2:0] addr, input logic [31:0] exp);
      exp_q.push_back(exp);
      bus.reg_sel  = 1'b1;
      bus.reg_we   = 1'b0;
      bus.reg_addr = addr;
      tick(1);
      bus.reg_sel  = 1'b0;
      chk(tag, bus.reg_rdata, exp_q.pop_front());
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst_n         = 1'b0;
      irq_req       = '0;
      bus.reg_sel   = 1'b0;
      bus.reg_we    = 1'b0;
      bus.reg_addr  = '0;
      bus.reg_wdata = '0;
      tick(3);
      chk("rst_cpu_int", cpu_int, 0);
      chk("rst_id", cpu_int_id, 0);
      chk("rst_ack", irq_ack, 0);
      chk("rst_rdata", bus.reg_rdata, 0);
      rst_n = 1'b1;
      tick(1);

      // Level ch1: interrupt four edges after the request rises.
      reg_write(INTC_ENABLE, 32'h2);
      irq_req[1] = 1'b1;
      tick(3);
      chk("lvl_edge3_int", cpu_int, 0);
      tick(1);
      chk("lvl_edge4_int", cpu_int, 1);
      chk("lvl_edge4_id", cpu_int_id, 1);
      reg_read("raw1", INTC_RAW, 32'h2);
      reg_read("pend1", INTC_PENDING, 32'h2);
      reg_read("claim1", INTC_CLAIM, 32'h8000_0001);
      chk("ack1_pulse", irq_ack, 4'b0010);
      tick(1);
      chk("ack1_end", irq_ack, 0);
      chk("int_after_claim1", cpu_int, 0);

      // Edge ch2 while ch1 in service: held off until COMPLETE(1).
      reg_write(INTC_MODE, 32'h4);
      reg_write(INTC_ENABLE, 32'h6);
      irq_req[1] = 1'b0;
      irq_req[2] = 1'b1;
      tick(2);
      irq_req[2] = 1'b0;
      tick(4);
      chk("ch2_blocked", cpu_int, 0);
      reg_read("pend_ch2", INTC_PENDING, 32'h4);
      reg_write(INTC_COMPLETE, 32'h1);
      tick(1);
      chk("ch2_int", cpu_int, 1);
      chk("ch2_id", cpu_int_id, 2);
      reg_read("claim2", INTC_CLAIM, 32'h8000_0002);
      chk("ack2_pulse", irq_ack, 4'b0100);
      reg_read("pend_ch2_clr", INTC_PENDING, 32'h0);
      reg_write(INTC_COMPLETE, 32'h2);

      // Nesting: ch3 in service, ch0 edge preempts.
      reg_write(INTC_MODE, 32'h5);
      reg_write(INTC_ENABLE, 32'hF);
      reg_read("mode_rd", INTC_MODE, 32'h5);
      irq_req[3] = 1'b1;
      tick(4);
      chk("ch3_int", cpu_int, 1);
      chk("ch3_id", cpu_int_id, 3);
      reg_read("claim3", INTC_CLAIM, 32'h8000_0003);
      irq_req[0] = 1'b1;
      tick(2);
      irq_req[0] = 1'b0;
      tick(3);
      chk("nest_int", cpu_int, 1);
      chk("nest_id", cpu_int_id, 0);
      reg_read("claim0", INTC_CLAIM, 32'h8000_0000);
      chk("ack0_pulse", irq_ack, 4'b0001);
      tick(1);
      chk("both_insvc_int", cpu_int, 0);
      reg_read("claim_none", INTC_CLAIM, 32'h0);
      chk("claim_none_ack", irq_ack, 0);
      reg_write(INTC_COMPLETE, 32'h0);
      tick(1);
      chk("complete0_int", cpu_int, 0);
      reg_write(INTC_COMPLETE, 32'h7);
      tick(1);
      chk("complete7_int", cpu_int, 0);
      reg_write(INTC_COMPLETE, 32'h3);
      tick(1);
      chk("lvl_reelig_int", cpu_int, 1);
      chk("lvl_reelig_id", cpu_int_id, 3);
      reg_read("claim3b", INTC_CLAIM, 32'h8000_0003);
      irq_req[3] = 1'b0;
      reg_write(INTC_COMPLETE, 32'h3);
      tick(4);

      // Edge on ch2 lands in the same cycle as its W1C: edge wins.
      irq_req[2] = 1'b1;
      tick(2);
      reg_write(INTC_PENDING, 32'h4);
      reg_read("edge_vs_w1c", INTC_PENDING, 32'h4);
      reg_write(INTC_PENDING, 32'h4);
      reg_read("w1c_clears", INTC_PENDING, 32'h0);
      irq_req[2] = 1'b0;

      // Upper ENABLE bits ignored; disabled pending channel keeps pending.
      reg_write(INTC_ENABLE, 32'hFFFF_FFF7);
      reg_read("en_mask", INTC_ENABLE, 32'h7);
      irq_req[3] = 1'b1;
      tick(5);
      chk("disabled_int", cpu_int, 0);
      reg_read("disabled_pend", INTC_PENDING, 32'h8);
      reg_write(INTC_PENDING, 32'h8);
      reg_read("lvl_w1c_ignored", INTC_PENDING, 32'h8);
      reg_read("unmapped6", 3'd6, 32'h0);

      // Reset asserted right after a claim edge.
      reg_write(INTC_ENABLE, 32'h8);
      tick(2);
      chk("pre_rst_int", cpu_int, 1);
      bus.reg_sel  = 1'b1;
      bus.reg_we   = 1'b0;
      bus.reg_addr = INTC_CLAIM;
      exp_q.push_back(32'h8000_0003);
      tick(1);
      bus.reg_sel = 1'b0;
      chk("pre_rst_rdata", bus.reg_rdata, exp_q.pop_front());
      chk("pre_rst_ack", irq_ack, 4'b1000);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rdata", bus.reg_rdata, 0);
      chk("mid_rst_ack", irq_ack, 0);
      chk("mid_rst_int", cpu_int, 0);
      chk("mid_rst_id", cpu_int_id, 0);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      reg_read("post_rst_en", INTC_ENABLE, 32'h0);
      chk("post_rst_int", cpu_int, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
